// File: rtl/memctrl_arb_if.sv
// Requester-side and MEMCTRL-side signal bundle for the round-robin memory scheduler.
// The slave modport is the scheduler; the master modport is everything around it.
interface memctrl_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      REQ;
    logic [NREQ-1:0]      RNW;
    logic [16*NREQ-1:0]   REQ_ADDR;
    logic [8*NREQ-1:0]    REQ_WDATA;
    logic [NREQ-1:0]      GNT;
    logic [NREQ-1:0]      ACK;
    logic [7:0]           RDATA;
    logic                 BUSY;
    logic [15:0]          ADDR;
    logic                 CE;
    logic                 CSB;
    logic                 WEB;
    logic                 OEB;
    logic [7:0]           IDATA;
    logic [7:0]           ODATA;

    modport master (
        output REQ, RNW, REQ_ADDR, REQ_WDATA, ODATA,
        input  GNT, ACK, RDATA, BUSY, ADDR, CE, CSB, WEB, OEB, IDATA
    );

    modport slave (
        input  REQ, RNW, REQ_ADDR, REQ_WDATA, ODATA,
        output GNT, ACK, RDATA, BUSY, ADDR, CE, CSB, WEB, OEB, IDATA
    );
endinterface

// File: rtl/memctrl_arb.sv
// Round-robin scheduler serialising NREQ requesters onto MEMCTRL's single strobe port.
// Every output is a flop loaded from the next-state logic, so strobes appear one cycle after arbitration.
module memctrl_arb #(
    parameter int NREQ     = 2,
    parameter int RD_LAT   = 1,
    parameter int IDLE_CYC = 1
) (
    input  logic          CLK,
    input  logic          RSTN,
    memctrl_arb_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int R  = (IDLE_CYC > RD_LAT) ? IDLE_CYC : RD_LAT;
    localparam logic [2:0] R_END  = 3'(R);
    localparam logic [2:0] RD_END = 3'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        RECOV
    } state_t;

    state_t           state_q, state_n;
    logic [IW-1:0]    last_q, last_n;
    logic [2:0]       rcnt_q, rcnt_n;
    logic             rd_pend_q, rd_pend_n;
    logic [15:0]      addr_q, addr_n;
    logic [7:0]       idata_q, idata_n;
    logic [7:0]       rdata_q, rdata_n;
    logic             ce_q, ce_n;
    logic             csb_q, csb_n;
    logic             web_q, web_n;
    logic             oeb_q, oeb_n;
    logic [NREQ-1:0]  gnt_q, gnt_n;
    logic [NREQ-1:0]  ack_q, ack_n;
    logic             busy_q, busy_n;

    logic             any_req;
    logic             found;
    logic             grant;
    int               cand;
    logic [IW-1:0]    win;
    logic [NREQ-1:0]  win_oh;
    logic [NREQ-1:0]  last_oh;
    logic [15:0]      win_addr;
    logic [7:0]       win_wdata;
    logic             win_rnw;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        any_req = |bus.REQ;
        found   = 1'b0;
        win     = last_q;
        cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_q) + k) % NREQ;
            if (!found && bus.REQ[cand]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
        win_oh          = '0;
        win_oh[win]     = 1'b1;
        last_oh         = '0;
        last_oh[last_q] = 1'b1;
        win_addr        = bus.REQ_ADDR[16*int'(win) +: 16];
        win_wdata       = bus.REQ_WDATA[8*int'(win) +: 8];
        win_rnw         = bus.RNW[win];
    end

    always_comb begin
        state_n   = state_q;
        last_n    = last_q;
        rcnt_n    = rcnt_q;
        rd_pend_n = rd_pend_q;
        addr_n    = addr_q;
        rdata_n   = rdata_q;
        idata_n   = 8'h00;
        ce_n      = 1'b0;
        csb_n     = 1'b1;
        web_n     = 1'b1;
        oeb_n     = 1'b1;
        gnt_n     = '0;
        ack_n     = '0;
        grant     = 1'b0;

        case (state_q)
            IDLE: begin
                grant = any_req;
            end
            STROBE: begin
                state_n = RECOV;
                rcnt_n  = 3'd1;
                if (!rd_pend_q) begin
                    ack_n = last_oh;
                end
            end
            RECOV: begin
                // The ACK is computed from the old owner before any new grant moves the pointer.
                if (rd_pend_q && (rcnt_q == RD_END)) begin
                    rdata_n   = bus.ODATA;
                    ack_n     = last_oh;
                    rd_pend_n = 1'b0;
                end
                if (rcnt_q == R_END) begin
                    state_n = IDLE;
                    grant   = any_req;
                end else begin
                    rcnt_n = rcnt_q + 3'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (grant) begin
            state_n   = STROBE;
            last_n    = win;
            rd_pend_n = win_rnw;
            addr_n    = win_addr;
            ce_n      = 1'b1;
            csb_n     = 1'b0;
            gnt_n     = win_oh;
            if (win_rnw) begin
                oeb_n = 1'b0;
            end else begin
                web_n   = 1'b0;
                idata_n = win_wdata;
            end
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            last_q    <= IW'(NREQ - 1);
            rcnt_q    <= 3'd0;
            rd_pend_q <= 1'b0;
            addr_q    <= 16'h0000;
            idata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            ce_q      <= 1'b0;
            csb_q     <= 1'b1;
            web_q     <= 1'b1;
            oeb_q     <= 1'b1;
            gnt_q     <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            last_q    <= last_n;
            rcnt_q    <= rcnt_n;
            rd_pend_q <= rd_pend_n;
            addr_q    <= addr_n;
            idata_q   <= idata_n;
            rdata_q   <= rdata_n;
            ce_q      <= ce_n;
            csb_q     <= csb_n;
            web_q     <= web_n;
            oeb_q     <= oeb_n;
            gnt_q     <= gnt_n;
            ack_q     <= ack_n;
            busy_q    <= busy_n;
        end
    end

    assign bus.ADDR  = addr_q;
    assign bus.IDATA = idata_q;
    assign bus.RDATA = rdata_q;
    assign bus.CE    = ce_q;
    assign bus.CSB   = csb_q;
    assign bus.WEB   = web_q;
    assign bus.OEB   = oeb_q;
    assign bus.GNT   = gnt_q;
    assign bus.ACK   = ack_q;
    assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_memctrl_arb.sv
// Directed bench for memctrl_arb: one default instance plus one with a stretched read latency.
// Strobe groups are compared as {CE,CSB,WEB,OEB}: idle 0111, write 1001, read 1010.
module tb_memctrl_arb;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vector_count = 0;
    int   miss_count   = 0;
    int   idx [2];

    memctrl_arb_if #(.NREQ(2)) bus0 ();
    memctrl_arb_if #(.NREQ(2)) bus3 ();

    memctrl_arb #(.NREQ(2), .RD_LAT(1), .IDLE_CYC(1)) dut (
        .CLK  (clk),
        .RSTN (rst_n),
        .bus  (bus0)
    );

    memctrl_arb #(.NREQ(2), .RD_LAT(3), .IDLE_CYC(1)) dut_lat3 (
        .CLK  (clk),
        .RSTN (rst_n),
        .bus  (bus3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vector_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] strobes0();
        return 32'({bus0.CE, bus0.CSB, bus0.WEB, bus0.OEB});
    endfunction

    function automatic logic [31:0] strobes3();
        return 32'({bus3.CE, bus3.CSB, bus3.WEB, bus3.OEB});
    endfunction

    function automatic logic [15:0] expAddr(input int r, input int i);
        return (r == 1 ? 16'hC000 : 16'h0000) + 16'(100 * i);
    endfunction

    function automatic logic [7:0] expData(input int r, input int i);
        return {4'(r + 1), 4'(i)};
    endfunction

    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] rnw,
                                 input logic [31:0] addr, input logic [15:0] wdata);
        bus0.REQ       = req;
        bus0.RNW       = rnw;
        bus0.REQ_ADDR  = addr;
        bus0.REQ_WDATA = wdata;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".strobes"}, strobes0(), 32'h7);
        checkOutput({tag, ".addr"},    32'(bus0.ADDR), 32'h0);
        checkOutput({tag, ".idata"},   32'(bus0.IDATA), 32'h0);
        checkOutput({tag, ".gnt"},     32'(bus0.GNT), 32'h0);
        checkOutput({tag, ".ack"},     32'(bus0.ACK), 32'h0);
        checkOutput({tag, ".rdata"},   32'(bus0.RDATA), 32'h0);
        checkOutput({tag, ".busy"},    32'(bus0.BUSY), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(2'b00, 2'b00, 32'h0, 16'h0);
        bus0.ODATA = 8'h00;
        bus3.REQ = 2'b00; bus3.RNW = 2'b00; bus3.REQ_ADDR = '0; bus3.REQ_WDATA = '0; bus3.ODATA = 8'h00;

        // Reset held with requests pending: everything stays idle.
        bus0.REQ = 2'b11;
        for (int c = 0; c < 4; c++) begin
            step();
            checkResetState("reset");
        end
        checkOutput("reset.lat3_rdata", 32'(bus3.RDATA), 32'h0);
        bus0.REQ = 2'b00;
        rst_n = 1'b1;
        step();

        // Single write from requester 0.
        applyStimulus(2'b01, 2'b00, 32'h0000_4064, 16'h00A5);
        step();
        checkOutput("wr.strobes", strobes0(), 32'h9);
        checkOutput("wr.addr",    32'(bus0.ADDR), 32'h4064);
        checkOutput("wr.idata",   32'(bus0.IDATA), 32'hA5);
        checkOutput("wr.gnt",     32'(bus0.GNT), 32'h1);
        checkOutput("wr.busy",    32'(bus0.BUSY), 32'h1);
        applyStimulus(2'b00, 2'b00, 32'h0000_4064, 16'h00A5);
        step();
        checkOutput("wr.rec_strobes", strobes0(), 32'h7);
        checkOutput("wr.ack",         32'(bus0.ACK), 32'h1);
        checkOutput("wr.rec_idata",   32'(bus0.IDATA), 32'h0);
        checkOutput("wr.rec_gnt",     32'(bus0.GNT), 32'h0);
        step();
        checkOutput("wr.idle_busy", 32'(bus0.BUSY), 32'h0);
        checkOutput("wr.idle_ack",  32'(bus0.ACK), 32'h0);
        checkOutput("wr.rdata",     32'(bus0.RDATA), 32'h0);

        // Read-back of the same location.
        applyStimulus(2'b01, 2'b01, 32'h0000_4064, 16'h0000);
        bus0.ODATA = 8'hA5;
        step();
        checkOutput("rd.strobes", strobes0(), 32'hA);
        checkOutput("rd.addr",    32'(bus0.ADDR), 32'h4064);
        checkOutput("rd.idata",   32'(bus0.IDATA), 32'h0);
        checkOutput("rd.gnt",     32'(bus0.GNT), 32'h1);
        bus0.REQ = 2'b00;
        step();
        checkOutput("rd.rec_strobes", strobes0(), 32'h7);
        checkOutput("rd.rec_ack",     32'(bus0.ACK), 32'h0);
        checkOutput("rd.rec_rdata",   32'(bus0.RDATA), 32'h0);
        step();
        checkOutput("rd.rdata", 32'(bus0.RDATA), 32'hA5);
        checkOutput("rd.ack",   32'(bus0.ACK), 32'h1);
        checkOutput("rd.busy",  32'(bus0.BUSY), 32'h0);
        bus0.ODATA = 8'h00;
        step();
        checkOutput("rd.ack_pulse", 32'(bus0.ACK), 32'h0);
        checkOutput("rd.hold",      32'(bus0.RDATA), 32'hA5);

        // Contention: both requesters stream five writes each from a fresh reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idx[0] = 0;
        idx[1] = 0;
        bus0.RNW = 2'b00;
        bus0.REQ_ADDR  = {expAddr(1, 0), expAddr(0, 0)};
        bus0.REQ_WDATA = {expData(1, 0), expData(0, 0)};
        bus0.REQ = 2'b11;
        for (int g = 0; g < 10; g++) begin
            int r;
            r = g % 2;
            step();
            checkOutput($sformatf("rr%0d.gnt", g),     32'(bus0.GNT), 32'(2'b01 << r));
            checkOutput($sformatf("rr%0d.strobes", g), strobes0(), 32'h9);
            checkOutput($sformatf("rr%0d.addr", g),    32'(bus0.ADDR), 32'(expAddr(r, idx[r])));
            checkOutput($sformatf("rr%0d.idata", g),   32'(bus0.IDATA), 32'(expData(r, idx[r])));
            idx[r] = idx[r] + 1;
            if (idx[r] == 5) begin
                bus0.REQ[r] = 1'b0;
            end else begin
                bus0.REQ_ADDR[16*r +: 16] = expAddr(r, idx[r]);
                bus0.REQ_WDATA[8*r +: 8]  = expData(r, idx[r]);
            end
            step();
            checkOutput($sformatf("rr%0d.rec_gnt", g), 32'(bus0.GNT), 32'h0);
            checkOutput($sformatf("rr%0d.ack", g),     32'(bus0.ACK), 32'(2'b01 << r));
            checkOutput($sformatf("rr%0d.rec_ce", g),  32'(bus0.CE), 32'h0);
        end
        step();
        checkOutput("rr.end_busy", 32'(bus0.BUSY), 32'h0);
        checkOutput("rr.end_gnt",  32'(bus0.GNT), 32'h0);

        // Stretched read latency with a back-to-back second read queued.
        bus3.REQ = 2'b01;
        bus3.RNW = 2'b01;
        bus3.REQ_ADDR = {16'h0000, 16'h1234};
        bus3.ODATA = 8'hEE;
        step();
        checkOutput("lat.strobes", strobes3(), 32'hA);
        checkOutput("lat.gnt",     32'(bus3.GNT), 32'h1);
        checkOutput("lat.addr",    32'(bus3.ADDR), 32'h1234);
        bus3.REQ_ADDR = {16'h0000, 16'h5678};
        for (int c = 2; c <= 4; c++) begin
            step();
            checkOutput($sformatf("lat.t%0d_strobes", c), strobes3(), 32'h7);
            checkOutput($sformatf("lat.t%0d_ack", c),     32'(bus3.ACK), 32'h0);
            checkOutput($sformatf("lat.t%0d_gnt", c),     32'(bus3.GNT), 32'h0);
            checkOutput($sformatf("lat.t%0d_rdata", c),   32'(bus3.RDATA), 32'h0);
        end
        bus3.ODATA = 8'h3C;
        step();
        checkOutput("lat.rdata",    32'(bus3.RDATA), 32'h3C);
        checkOutput("lat.ack",      32'(bus3.ACK), 32'h1);
        checkOutput("lat.strobes2", strobes3(), 32'hA);
        checkOutput("lat.gnt2",     32'(bus3.GNT), 32'h1);
        checkOutput("lat.addr2",    32'(bus3.ADDR), 32'h5678);
        bus3.REQ = 2'b00;
        bus3.ODATA = 8'h77;
        step();
        step();
        step();
        checkOutput("lat.hold", 32'(bus3.RDATA), 32'h3C);
        step();
        checkOutput("lat.rdata2", 32'(bus3.RDATA), 32'h77);
        checkOutput("lat.ack2",   32'(bus3.ACK), 32'h1);
        checkOutput("lat.busy",   32'(bus3.BUSY), 32'h0);

        // Reset in the middle of a read abandons it without ACK or RDATA update.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        applyStimulus(2'b01, 2'b11, 32'h0100_4064, 16'h0000);
        bus0.ODATA = 8'h5A;
        step();
        checkOutput("rstmid.gnt", 32'(bus0.GNT), 32'h1);
        bus0.REQ = 2'b11;
        step();
        rst_n = 1'b0;
        #1;
        checkResetState("rstmid.async");
        step();
        checkResetState("rstmid.held");
        rst_n = 1'b1;
        step();
        checkOutput("rstmid.regnt",   32'(bus0.GNT), 32'h1);
        checkOutput("rstmid.rdata",   32'(bus0.RDATA), 32'h0);
        checkOutput("rstmid.strobes", strobes0(), 32'hA);
        bus0.REQ = 2'b00;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule

// File: doc/memctrl_arb.md
Name: memctrl_arb

Overview:
Round-robin access scheduler in front of MEMCTRL, sharing its single 16-bit-address / 8-bit-data port among NREQ requesters. It serialises read and write requests into MEMCTRL's one-cycle strobe protocol: one active cycle with CE=1/CSB=0, followed by recovery cycles with all strobes inactive. Read data is captured after a fixed latency and returned to the owning requester with a one-cycle acknowledge.

Parameters:
NREQ, 2, number of requesters; legal range 2..8.
RD_LAT, 1, cycles from the end of the read-strobe cycle to the ODATA capture edge; legal range 1..7.
IDLE_CYC, 1, minimum number of inactive cycles after every strobe; legal range 1..7.

Ports:
CLK  in  1  clock; all logic on the rising edge
RSTN  in  1  reset; asynchronous, active-low
REQ  in  NREQ  per-requester request level
RNW  in  NREQ  per-requester direction; 1=read, 0=write
REQ_ADDR  in  16*NREQ  per-requester address; slice i = [16i+15:16i]
REQ_WDATA  in  8*NREQ  per-requester write data; slice i = [8i+7:8i]
GNT  out  NREQ  one-hot, one-cycle pulse: request taken
ACK  out  NREQ  one-hot, one-cycle pulse: write done / RDATA valid
RDATA  out  8  last captured read data
BUSY  out  1  high when state is not IDLE
ADDR  out  16  to MEMCTRL
CE  out  1  to MEMCTRL
CSB  out  1  to MEMCTRL, active-low
WEB  out  1  to MEMCTRL, active-low write
OEB  out  1  to MEMCTRL, active-low output enable
IDATA  out  8  write data to MEMCTRL
ODATA  in  8  read data from MEMCTRL

Behaviour:
- All outputs are registered.
- Reset values (applied immediately, asynchronously):
  - ADDR=0, IDATA=0, RDATA=0.
  - CE=0, CSB=1, WEB=1, OEB=1.
  - GNT=0, ACK=0, BUSY=0.
  - State=IDLE, round-robin pointer LAST=NREQ-1, recovery counter=0, pending-read flags cleared.
- FSM states: IDLE, STROBE, RECOV.
- Arbitration:
  - Evaluated in IDLE and in the final RECOV cycle.
  - Winner w = first set REQ bit searching LAST+1, LAST+2, … modulo NREQ.
  - At that edge: latch REQ_ADDR[w], REQ_WDATA[w] and RNW[w]; set LAST=w; go to STROBE.
  - A grant is committed once sampled. Dropping REQ afterwards does not cancel it.
  - A REQ deasserted before it is sampled is simply withdrawn.
- STROBE (exactly 1 cycle):
  - CE=1, CSB=0, GNT[w]=1, ADDR=latched address.
  - Write: WEB=0, OEB=1, IDATA=latched data.
  - Read: WEB=1, OEB=0, IDATA=0.
  - Next state: RECOV.
- RECOV (length R = max(IDLE_CYC, RD_LAT) cycles):
  - CE=0, CSB=1, WEB=1, OEB=1, IDATA=0; ADDR holds its last value.
  - Exit to STROBE if any REQ is set in the final RECOV cycle, else to IDLE.
- Requester handshake:
  - Hold REQ, RNW and payload stable until GNT is seen.
  - May keep REQ high for back-to-back accesses.
- Throughput: one access per 1+R cycles; 2 cycles with defaults.
- Write completion: ACK[w]=1 in the first RECOV cycle.
- Read completion:
  - ODATA is captured into RDATA on the rising edge ending RECOV cycle number RD_LAT.
  - ACK[w]=1 in the following cycle, which may fall in IDLE or in the next STROBE.
  - RDATA holds until the next read capture; writes never change RDATA.
  - A read ACK and a GNT may coincide in the same cycle; they may target different requesters.
- Address and data: passed through unmodified; bank selection (ADDR[15:14]) is left to MEMCTRL.
- RSTN low mid-operation: the access is abandoned; no ACK or RDATA update for it; all outputs idle immediately.
- REQ=0 everywhere: the FSM stays in IDLE with outputs at idle values.

Test Plan:
1. Reset: hold RSTN=0 for 4 cycles with REQ=all-ones → CE=0, CSB=1, WEB=1, OEB=1, ADDR=0, IDATA=0, GNT=0, ACK=0, RDATA=0, BUSY=0 throughout.
2. Single write: REQ[0]=1, RNW[0]=0, addr 0x4064, data 0xA5 sampled at cycle T → at T+1: CE=1, CSB=0, WEB=0, OEB=1, ADDR=0x4064, IDATA=0xA5, GNT=01; at T+2: CE=0, CSB=1, ACK=01, IDATA=0; BUSY=0 at T+3.
3. Read-back: REQ[0]=1, RNW[0]=1, addr 0x4064 at T → at T+1: CE=1, CSB=0, OEB=0, WEB=1; ODATA=0xA5 captured at the end of T+2; RDATA=0xA5 and ACK=01 at T+3.
4. Contention: REQ=11 held continuously, writes only, starting after reset → GNT pattern 01, 10, 01, 10 on strobes spaced exactly 2 cycles apart; five writes per requester to 0x0000+100i and 0xC000+100i are each issued once.
5. Latency stretch: RD_LAT=3, IDLE_CYC=1, read at T → STROBE at T+1, RECOV at T+2..T+4, RDATA and ACK at T+5; the next STROBE is no earlier than T+5.
6. Reset mid-read: assert RSTN=0 during T+2 of scenario 3 → no ACK pulse, RDATA stays 0, outputs idle; after release with REQ=11, requester 0 is granted first.
